// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the router output-port reader.
//   Header byte layout is {len[7:2], addr[1:0]}.
//   rd_state_t : reader FSM states (what the next FIFO read will fetch).
//   beat_t     : one client beat as held in the skid buffer.
package router_pkg;

    localparam int DATA_W   = 8;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int MAX_LEN  = 63;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [1:0] {
        IDLE,   // next read fetches a header
        HDR,    // header in flight / held; next read is payload (or parity for len 0)
        PLD,    // payload reads remaining in cnt
        PAR     // next read fetches the parity byte
    } rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

endpackage

// File: rtl/router_out_if.sv
// router_out_if: FIFO-side and client-side signals of one router output port.
//   master : the reader engine (drives read_enb and the client stream)
//   slave  : the environment (FIFO/sync block and destination client)
interface router_out_if #(
    parameter int DATA_W = 8
);
    logic              vld_out;
    logic              soft_reset;
    logic [DATA_W-1:0] fifo_dout;
    logic              read_enb;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              sop;
    logic              eop;
    logic              pkt_err;
    logic              pkt_abort;

    modport master (
        input  vld_out, soft_reset, fifo_dout, dout_ready,
        output read_enb, dout, dout_valid, sop, eop, pkt_err, pkt_abort
    );

    modport slave (
        output vld_out, soft_reset, fifo_dout, dout_ready,
        input  read_enb, dout, dout_valid, sop, eop, pkt_err, pkt_abort
    );
endinterface

// File: rtl/router_rd_skid.sv
// router_rd_skid: 2-entry in-order buffer of client beats {data, sop, eop}.
//   clock/reset : rising-edge clock, async active-low reset
//   flush       : drop all entries this edge (push ignored)
//   push/push_beat, pop : write and read strobes (pop only when valid)
//   head/valid  : oldest entry, presented to the client
//   occ         : number of entries held (0..2)
module router_rd_skid
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic       valid,
    output logic [1:0] occ
);

    beat_t      e0_q, e0_d, e1_q, e1_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) e0_d = push_beat;
                    else               e1_d = push_beat;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new beat lands behind whatever remains.
                    if (occ_q == 2'd1) begin
                        e0_d = push_beat;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head  = e0_q;
    assign valid = (occ_q != 2'd0);
    assign occ   = occ_q;

endmodule

// File: rtl/router_out_reader.sv
// router_out_reader: read-side engine for one router output port.
//   Drains the output FIFO, parses header/payload/parity and presents the bytes
//   on a valid/ready client stream with sop/eop/pkt_err, plus a pkt_abort pulse
//   when soft_reset kills a packet.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : router_out_if.master (FIFO read side + client stream)
//   Optional: PARITY_CHECK_EN adds the running-XOR parity check to pkt_err;
//   without it pkt_err reports header address mismatch only.
module router_out_reader
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PORT_ID = 0
) (
    input  logic         clock,
    input  logic         reset,
    router_out_if.master bus
);

    localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(PORT_ID);

    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             infl_q, infl_d, infl_sop_q, infl_sop_d, infl_eop_q, infl_eop_d;
    logic             err_q, err_d, abort_q, abort_d;
`ifdef PARITY_CHECK_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    beat_t            push_beat, head;
    logic             push, pop, skid_vld;
    logic [1:0]       occ;

    logic             hdr_now, can_rd, rd;
    logic [LEN_W-1:0] hdr_len;
    logic [2:0]       occ_eff;

    router_rd_skid u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.soft_reset),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .valid     (skid_vld),
        .occ       (occ)
    );

    always_comb begin
        pop     = skid_vld & bus.dout_ready;
        // The header byte is on fifo_dout only in the first HDR cycle; a stalled
        // HDR falls back to the captured length.
        hdr_now = (state_q == HDR) & infl_q;
        hdr_len = hdr_now ? bus.fifo_dout[LEN_MSB:LEN_LSB] : len_q;
        // Credit counts a beat leaving this cycle as already gone, so a
        // continuously ready client sees one byte per cycle.
        occ_eff = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

        unique case (state_q)
            HDR:     can_rd = (hdr_len != '0);
            default: can_rd = 1'b1;
        endcase

        rd = reset & bus.vld_out & ~bus.soft_reset & (occ_eff < 3'd2) & can_rd;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        err_d      = err_q;
        infl_d     = rd;
        infl_sop_d = rd & (state_q == IDLE);
        infl_eop_d = rd & (state_q == PAR);
        abort_d    = bus.soft_reset & ((state_q != IDLE) | (occ != 2'd0));
        push       = infl_q & ~bus.soft_reset;
        push_beat  = '{data: bus.fifo_dout, sop: infl_sop_q, eop: infl_eop_q};
`ifdef PARITY_CHECK_EN
        acc_d      = acc_q;
`endif

        if (hdr_now) begin
            len_d  = bus.fifo_dout[LEN_MSB:LEN_LSB];
            addr_d = bus.fifo_dout[ADDR_MSB:ADDR_LSB];
        end

        unique case (state_q)
            IDLE: if (rd) state_d = HDR;
            HDR: begin
                if (hdr_len == '0) begin
                    state_d = PAR;
                end else if (rd) begin
                    cnt_d   = hdr_len - LEN_W'(1);
                    state_d = (hdr_len == LEN_W'(1)) ? PAR : PLD;
                end
            end
            PLD: begin
                if (rd) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = PAR;
                end
            end
            PAR: if (rd) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Arriving bytes: fold header/payload into the accumulator and judge the
        // packet when its parity byte lands. Only one EOP can sit in the skid at
        // a time, so a single err flag serves the EOP beat at the head.
        if (push) begin
`ifdef PARITY_CHECK_EN
            if (infl_sop_q)      acc_d = bus.fifo_dout;
            else if (!infl_eop_q) acc_d = acc_q ^ bus.fifo_dout;
            if (infl_eop_q)
                err_d = (acc_q != bus.fifo_dout) | (addr_q != PORT_ADDR);
`else
            if (infl_eop_q)
                err_d = (addr_q != PORT_ADDR);
`endif
        end

        if (bus.soft_reset) begin
            state_d    = IDLE;
            cnt_d      = '0;
            err_d      = 1'b0;
            infl_d     = 1'b0;
            infl_sop_d = 1'b0;
            infl_eop_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            infl_q     <= infl_d;
            infl_sop_q <= infl_sop_d;
            infl_eop_q <= infl_eop_d;
`ifdef PARITY_CHECK_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign bus.read_enb   = rd;
    assign bus.dout       = head.data;
    assign bus.dout_valid = skid_vld;
    assign bus.sop        = skid_vld & head.sop;
    assign bus.eop        = skid_vld & head.eop;
    assign bus.pkt_err    = skid_vld & head.eop & err_q;
    assign bus.pkt_abort  = abort_q;

endmodule

// File: tb/tb_router_out_reader.sv
module tb_router_out_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    router_out_if #(.DATA_W(8)) bus();

    router_out_reader #(.DATA_W(8), .PORT_ID(0)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    logic [7:0] pend[$];
    int total = 0, bad = 0;
    int cyc = 0, rd_cnt = 0, overread = 0, beats = 0;
    int first_cyc = -1, last_cyc = -1;
    bit vld_gate = 1'b0;

    // FIFO model: byte appears on fifo_dout the cycle after read_enb.
    initial begin : fifo_model
        bus.fifo_dout = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (bus.read_enb === 1'b1) begin
                rd_cnt++;
                if (fifo.size() != 0) bus.fifo_dout <= fifo.pop_front();
                else overread++;
            end
        end
    end

    initial begin : vld_model
        bus.vld_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.vld_out = vld_gate && (fifo.size() != 0);
        end
    end

    // Scoreboard: every accepted beat is popped and compared against expectations.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected got data=%h sop=%b eop=%b err=%b",
                             bus.dout, bus.sop, bus.eop, bus.pkt_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.dout, bus.sop, bus.eop, bus.pkt_err} !== {e.data, e.sop, e.eop, e.err}) begin
                        bad++;
                        $display("FAIL beat got data=%h sop=%b eop=%b err=%b want data=%h sop=%b eop=%b err=%b",
                                 bus.dout, bus.sop, bus.eop, bus.pkt_err, e.data, e.sop, e.eop, e.err);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Builds a packet, queues expected beats; bytes at index >= split go to pend.
    task automatic send_pkt(input logic [7:0] hdr, input bit bad_par, input int split);
        logic [7:0] b[$];
        logic [7:0] x, d, par;
        logic       err;
        int len;
        len = int'(hdr[7:2]);
        x = hdr;
        b.push_back(hdr);
        exp_q.push_back('{data: hdr, sop: 1'b1, eop: 1'b0, err: 1'b0});
        for (int i = 0; i < len; i++) begin
            d = 8'(8'h11 * (i + 1));
            x ^= d;
            b.push_back(d);
            exp_q.push_back('{data: d, sop: 1'b0, eop: 1'b0, err: 1'b0});
        end
        par = bad_par ? (x ^ 8'h11) : x;
`ifdef PARITY_CHECK_EN
        err = (par != x) || (hdr[1:0] != 2'd0);
`else
        err = (hdr[1:0] != 2'd0);
`endif
        b.push_back(par);
        exp_q.push_back('{data: par, sop: 1'b0, eop: 1'b1, err: err});
        for (int i = 0; i < b.size(); i++) begin
            if (split == 0 || i < split) fifo.push_back(b[i]);
            else pend.push_back(b[i]);
        end
    endtask

    task automatic drain(output bit ok);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        bus.soft_reset = 1'b0;
        bus.dout_ready = 1'b1;
        fifo.push_back(8'hAA);
        vld_gate = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.vld_out !== 1'b1 || bus.read_enb !== 1'b0) begin
            bad++;
            $display("FAIL reset_read got vld_out=%b read_enb=%b want 1/0", bus.vld_out, bus.read_enb);
        end
        total++;
        if ({bus.dout_valid, bus.sop, bus.eop, bus.pkt_err, bus.pkt_abort, bus.dout} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b sop=%b eop=%b err=%b abort=%b dout=%h want all 0",
                     bus.dout_valid, bus.sop, bus.eop, bus.pkt_err, bus.pkt_abort, bus.dout);
        end
        vld_gate = 1'b0;
        fifo.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        vld_gate = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int b0;
        b0 = beats;
        first_cyc = -1;
        send_pkt(8'h0C, 1'b0, 0);
        send_pkt(8'h0C, 1'b0, 0);
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_drain left=%0d want 0", exp_q.size()); end
        total++;
        if (beats - b0 != 10 || last_cyc - first_cyc != 9) begin
            bad++;
            $display("FAIL basic_throughput got beats=%0d span=%0d want 10/9", beats - b0, last_cyc - first_cyc);
        end
    endtask

    task automatic test_parity_err();
        bit ok;
        send_pkt(8'h0C, 1'b1, 0);
        send_pkt(8'h0D, 1'b0, 0);
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL parity_drain left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int b0, r0;
        logic [7:0] held;
        b0 = beats;
        send_pkt(8'h18, 1'b0, 0);
        for (int i = 0; i < 100 && beats < b0 + 2; i++) @(negedge clk);
        tick();
        bus.dout_ready = 1'b0;
        r0 = rd_cnt;
        @(negedge clk);
        held = bus.dout;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.dout !== held || bus.dout_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold got dout=%h valid=%b want %h/1", bus.dout, bus.dout_valid, held);
            end
        end
        total++;
        if (rd_cnt - r0 > 2 || bus.read_enb !== 1'b0) begin
            bad++;
            $display("FAIL bp_reads got extra_reads=%0d read_enb=%b want <=2/0", rd_cnt - r0, bus.read_enb);
        end
        tick();
        bus.dout_ready = 1'b1;
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_drain left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_vld_drop();
        bit ok;
        int r0;
        send_pkt(8'h10, 1'b0, 2);
        for (int i = 0; i < 50 && fifo.size() != 0; i++) tick();
        repeat (2) tick();
        r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.read_enb !== 1'b0) begin
                bad++;
                $display("FAIL drop_read got read_enb=%b want 0", bus.read_enb);
            end
        end
        tick();
        total++;
        if (rd_cnt != r0) begin bad++; $display("FAIL drop_count got %0d want %0d", rd_cnt, r0); end
        while (pend.size() != 0) fifo.push_back(pend.pop_front());
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL drop_drain left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_soft_reset();
        bit ok;
        int b0;
        b0 = beats;
        send_pkt(8'h28, 1'b0, 0);
        for (int i = 0; i < 100 && beats < b0 + 3; i++) @(negedge clk);
        tick();
        bus.soft_reset = 1'b1;
        fifo.delete();
        tick();
        bus.soft_reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (bus.dout_valid !== 1'b0 || bus.pkt_abort !== 1'b1) begin
            bad++;
            $display("FAIL abort_pulse got valid=%b abort=%b want 0/1", bus.dout_valid, bus.pkt_abort);
        end
        @(negedge clk);
        total++;
        if (bus.pkt_abort !== 1'b0) begin
            bad++;
            $display("FAIL abort_width got abort=%b want 0", bus.pkt_abort);
        end
        tick();
        send_pkt(8'h0C, 1'b0, 0);
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL abort_recover left=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_len0_max();
        bit ok;
        int b0;
        b0 = beats;
        send_pkt(8'h00, 1'b0, 0);
        send_pkt(8'hFC, 1'b0, 0);
        drain(ok);
        total++;
        if (!ok || beats - b0 != 67) begin
            bad++;
            $display("FAIL len_edges got beats=%0d left=%0d want 67/0", beats - b0, exp_q.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_parity_err();
        test_backpressure();
        test_vld_drop();
        test_soft_reset();
        test_len0_max();
        total++;
        if (overread != 0) begin
            bad++;
            $display("FAIL overread got %0d reads of empty fifo want 0", overread);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
